pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS fetch stage, replacing the plain PC register. It holds the current fetch address, advances it by a configurable step, and redirects it on branch, jump, call and return. Calls and returns use an internal circular return-address stack (RAS). A valid flag marks the one-cycle bubble after every redirect. The unit sits between the control/branch logic and the instruction memory address port.

---
 rtl/pc_unit.sv | 153 +++++++++++++++
 tb/tb_pc_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter for the MIPS fetch stage.
//
// Holds the current fetch address. Each non-stalled cycle it advances by STEP
// or redirects on ret, call, jump or a taken branch, in that priority order.
// Calls push their return address onto a small circular return-address stack
// (RAS) and rets pop it. instValid is low for the bubble cycle after a redirect.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   stall        hold PC, RAS and instValid; ignore all requests
//   branchTaken  redirect to (currentInst + STEP) + branchOffset
//   branchOffset two's-complement byte offset
//   jump         redirect to jumpTarget
//   jumpTarget   absolute target for jump and call
//   call         redirect to jumpTarget and push currentInst + STEP
//   ret          pop the RAS and redirect there (currentInst + STEP if empty)
//   currentInst  registered fetch address
//   nextInst     combinational value currentInst takes at the next edge
//   instValid    registered; currentInst is a real fetch, not a bubble
//   rasEmpty     RAS count is zero
//   rasFull      RAS count equals RAS_DEPTH
//   rasError     one-cycle pulse after an overflowing push or an empty pop
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 2,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branchTaken,
  input  logic [WIDTH-1:0] branchOffset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jumpTarget,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] currentInst,
  output logic [WIDTH-1:0] nextInst,
  output logic             instValid,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasError
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  // Explicit wrap so a non-power-of-two depth still forms a proper ring.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_MAX : p - 1'b1;
  endfunction

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [PTR_W-1:0] top_q, top_d;   // index of the newest entry
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] seq;
  logic [PTR_W-1:0] push_ptr;
  logic             push_en;

  assign seq      = pc_q + WIDTH'(STEP);
  // A push into a full ring lands on the oldest slot, overwriting it.
  assign push_ptr = ptr_inc(top_q);

  // NOTE: every variable gets a default before the if-chain so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    push_en = 1'b0;

    if (rst) begin
      // Pending push/pop is discarded; nextInst already shows RESET_PC.
      pc_d    = RESET_PC;
      valid_d = 1'b0;
      top_d   = PTR_MAX;
      cnt_d   = '0;
    end else if (!stall) begin
      valid_d = 1'b0;  // any redirect below leaves a bubble
      if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[top_q];
          top_d = ptr_dec(top_q);
          cnt_d = cnt_q - 1'b1;
        end else begin
          pc_d  = seq;
          err_d = 1'b1;
        end
      end else if (call) begin
        pc_d    = jumpTarget;
        push_en = 1'b1;
        top_d   = push_ptr;
        if (cnt_q == CNT_MAX) err_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (jump) begin
        pc_d = jumpTarget;
      end else if (branchTaken) begin
        pc_d = seq + branchOffset;
      end else begin
        pc_d    = seq;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      top_q   <= PTR_MAX;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the stack storage has no reset; count alone defines which entries
  // are live, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_en) ras_q[push_ptr] <= seq;
  end

  assign currentInst = pc_q;
  assign nextInst    = pc_d;
  assign instValid   = valid_q;
  assign rasEmpty    = (cnt_q == '0);
  assign rasFull     = (cnt_q == CNT_MAX);
  assign rasError    = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- scoreboard bench for pc_unit (default parameters).
// The stimulus process drives one cycle of inputs, and after the clock edge
// pushes the hand-computed state expected for that edge. An independent
// monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branchTaken, jump, call, ret;
  logic [15:0] branchOffset, jumpTarget;
  logic [15:0] currentInst, nextInst;
  logic        instValid, rasEmpty, rasFull, rasError;

  pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchOffset (branchOffset),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .call         (call),
    .ret          (ret),
    .currentInst  (currentInst),
    .nextInst     (nextInst),
    .instValid    (instValid),
    .rasEmpty     (rasEmpty),
    .rasFull      (rasFull),
    .rasError     (rasError)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] pc;
    logic        valid;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("step%0d {pc,valid,empty,full,err}", e.id),
            {43'd0, currentInst, instValid, rasEmpty, rasFull, rasError},
            {43'd0, e.pc, e.valid, e.empty, e.full, e.err});
    end
  end

  // Drive one cycle of requests, then record the state expected after the edge.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [15:0] off, input logic j, input logic c,
                      input logic rt, input logic [15:0] tgt,
                      input logic [15:0] e_pc, input logic e_v, input logic e_em,
                      input logic e_fu, input logic e_er);
    exp_t e;
    rst = r; stall = s; branchTaken = b; branchOffset = off;
    jump = j; call = c; ret = rt; jumpTarget = tgt;
    @(posedge clk);
    #1;
    e.id = step_no; e.pc = e_pc; e.valid = e_v;
    e.empty = e_em; e.full = e_fu; e.err = e_er;
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic idle(input logic [15:0] e_pc, input logic e_em);
    step(0, 0, 0, 16'h0, 0, 0, 0, 16'h0, e_pc, 1, e_em, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //    r s b off      j c r tgt       pc       v em fu er
    // Reset and free run, instValid low on the first cycle only.
    step(1,0,0,16'h0000,0,0,0,16'h0000, 16'h0000,0,1,0,0);
    step(1,0,0,16'h0000,0,0,0,16'h0000, 16'h0000,0,1,0,0);
    idle(16'h0002, 1);
    idle(16'h0004, 1);
    idle(16'h0006, 1);
    idle(16'h0008, 1);
    // Address wrap 0xFFFE -> 0x0000.
    step(0,0,0,16'h0000,1,0,0,16'hFFFE, 16'hFFFE,0,1,0,0);
    idle(16'h0000, 1);
    idle(16'h0002, 1);
    // Backward branch from 0x0010: 0x0012 - 16 = 0x0002.
    step(0,0,0,16'h0000,1,0,0,16'h0010, 16'h0010,0,1,0,0);
    step(0,0,1,16'hFFF0,0,0,0,16'h0000, 16'h0002,0,1,0,0);
    idle(16'h0004, 1);
    // Jump outranks a simultaneous branch.
    step(0,0,1,16'h0100,1,0,0,16'h0020, 16'h0020,0,1,0,0);
    // Nested call/ret.
    step(0,0,0,16'h0000,0,1,0,16'h0100, 16'h0100,0,0,0,0);
    idle(16'h0102, 0);
    idle(16'h0104, 0);
    step(0,0,0,16'h0000,0,1,0,16'h0200, 16'h0200,0,0,0,0);
    idle(16'h0202, 0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h0106,0,0,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h0022,0,1,0,0);
    idle(16'h0024, 1);
    // Five calls into a 4-deep RAS; the 5th also has jump set (call wins).
    step(0,0,0,16'h0000,0,1,0,16'h1000, 16'h1000,0,0,0,0);
    step(0,0,0,16'h0000,0,1,0,16'h2000, 16'h2000,0,0,0,0);
    step(0,0,0,16'h0000,0,1,0,16'h3000, 16'h3000,0,0,0,0);
    step(0,0,0,16'h0000,0,1,0,16'h4000, 16'h4000,0,0,1,0);
    step(0,0,0,16'h0000,1,1,0,16'h5000, 16'h5000,0,0,1,1);
    // Five rets: newest first, oldest (0x0026) lost, last one underflows.
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h4002,0,0,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h3002,0,0,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h2002,0,0,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h1002,0,1,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h1004,0,1,0,1);
    idle(16'h1006, 1);
    // ret together with call: ret acts, no push.
    step(0,0,0,16'h0000,0,1,0,16'h0500, 16'h0500,0,0,0,0);
    step(0,0,0,16'h0000,0,1,1,16'h0700, 16'h1008,0,1,0,0);
    // Back-to-back call then ret.
    step(0,0,0,16'h0000,0,1,0,16'h0600, 16'h0600,0,0,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h100A,0,1,0,0);
    idle(16'h100C, 1);
    // Stall with jump held for 3 cycles; RAS holds one entry (0x100E).
    step(0,0,0,16'h0000,0,1,0,16'h0800, 16'h0800,0,0,0,0);
    idle(16'h0802, 0);
    for (int i = 0; i < 3; i++)
      step(0,1,0,16'h0000,1,0,0,16'h0300, 16'h0802,1,0,0,0);
    idle(16'h0804, 0);
    // Stall holds a low instValid and blocks a pop.
    step(0,0,0,16'h0000,1,0,0,16'h0900, 16'h0900,0,0,0,0);
    step(0,1,0,16'h0000,0,0,0,16'h0000, 16'h0900,0,0,0,0);
    idle(16'h0902, 0);
    step(0,1,0,16'h0000,0,0,1,16'h0000, 16'h0902,1,0,0,0);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h100E,0,1,0,0);
    // Stalled ret on an empty RAS raises no error.
    step(0,1,0,16'h0000,0,0,1,16'h0000, 16'h100E,0,1,0,0);
    idle(16'h1010, 1);
    // Reset overrides call, jump and stall; the RAS comes back empty.
    step(0,0,0,16'h0000,0,1,0,16'h0A00, 16'h0A00,0,0,0,0);
    step(1,1,0,16'h0000,1,1,0,16'h0B00, 16'h0000,0,1,0,0);
    idle(16'h0002, 1);
    step(0,0,0,16'h0000,0,0,1,16'h0000, 16'h0004,0,1,0,1);
    idle(16'h0006, 1);

    // Let the monitor drain the queue, then confirm nothing was left over.
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
